pipelined_addsub: RTL and testbench
===================================

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits (>=2).
REQ-002 The block SHALL have parameter STAGES, default 2: pipeline depth; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-005 in_valid_i  input  1  operand beat valid.
REQ-006 in_ready_o  output  1  block accepts a beat this cycle.
REQ-007 a_i  input  WIDTH  operand A.
REQ-008 b_i  input  WIDTH  operand B.
REQ-009 sub_i  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid_o  output  1  result beat valid.
REQ-011 out_ready_i  input  1  downstream accepts result.
REQ-012 sum_o  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 cout_o  output  1  carry out of MSB (for subtract: 1 = no borrow).

Function
REQ-014 A beat SHALL be accepted when in_valid_i && in_ready_o; a result SHALL transfer when out_valid_o && out_ready_i.
REQ-015 Subtract SHALL be computed as A + ~B + 1, with sub_i as stage-0 carry-in; sub_i is captured with the beat.
REQ-016 Operands SHALL be split into STAGES chunks of W=WIDTH/STAGES bits; stage k adds chunk k (LSB first) plus the registered carry from stage k-1.
REQ-017 Higher operand chunks SHALL be skewed through delay registers so each chunk meets its carry; lower result chunks SHALL be delayed to align at the output.
REQ-018 Latency SHALL be exactly STAGES cycles from acceptance to out_valid_o with no stall; throughput one beat per cycle.
REQ-019 Each stage SHALL carry a valid bit; out_valid_o is the last stage's valid bit.
REQ-020 Stall = out_valid_o && !out_ready_i; during a stall every pipeline register, including valid bits, SHALL hold its value.
REQ-021 in_ready_o SHALL equal !stall (combinational from out_ready_i); accepting into an empty pipeline while output stalls is not required.
REQ-022 Simultaneous accept and output transfer SHALL both occur in the same cycle with no bubble.
REQ-023 Bubbles (in_valid_i=0 when ready) SHALL propagate as valid=0 stages; data registers in bubble stages are don't-care but SHALL not reach out_valid_o.
REQ-024 sum_o/cout_o SHALL remain stable while out_valid_o=1 and out_ready_i=0.

Reset
REQ-025 On rst_n_i=0 all valid bits, sum_o, cout_o and all data/skew registers SHALL clear to 0 immediately, independent of clk_i.
REQ-026 Reset mid-operation SHALL discard all in-flight beats; first post-reset acceptance behaves as into an empty pipeline.
REQ-027 in_ready_o SHALL be 1 during and after reset (out_valid_o=0).

Configuration
REQ-028 Macro ADDSUB_OVERFLOW_EN: when defined, output ovf_o (1 bit) SHALL report signed two's-complement overflow (carry into MSB XOR carry out of MSB), pipelined and aligned with sum_o, reset 0.
REQ-029 Without ADDSUB_OVERFLOW_EN, ovf_o and its logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-030 Shared package addsub_pkg SHALL hold the default WIDTH/STAGES constants and the sub-mode encoding constants (ADD=0, SUB=1).
REQ-031 One sub-module adder_slice (W-bit ripple add with carry-in, sum, carry-out, carry-into-MSB) SHALL be instantiated once per stage.

Verification (WIDTH=8, STAGES=2, out_ready_i=1 unless stated)
REQ-032 After reset, a=0x3C, b=0x05, sub=0 -> two cycles later out_valid_o=1, sum_o=0x41, cout_o=0.
REQ-033 a=0xFF, b=0x01, sub=0 -> sum_o=0x00, cout_o=1 (carry crosses stage boundary); with OVERFLOW_EN ovf_o=0.
REQ-034 a=0x05, b=0x07, sub=1 -> sum_o=0xFE, cout_o=0; a=0x80, b=0x01, sub=1 -> sum_o=0x7F, ovf_o=1.
REQ-035 Back-to-back beats 1+1, 2+2, 3+3 with out_ready_i=0 for 3 cycles after first result -> in_ready_o=0 during stall, results 0x02, 0x04, 0x06 delivered in order, none lost or duplicated.
REQ-036 Assert rst_n_i low between clock edges with two beats in flight -> out_valid_o, sum_o, cout_o drop to 0 immediately; no result emerges after release.

Source files
------------

// File: rtl/addsub_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : addsub_pkg                                                 |
// | Description : Shared constants for the pipelined adder/subtractor:       |
// |               default operand width and pipeline depth, and the          |
// |               encoding of the sub_i mode bit.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package addsub_pkg;

  localparam int   C_DEFAULT_WIDTH  = 8;
  localparam int   C_DEFAULT_STAGES = 2;

  // Mode encoding on sub_i. SUB doubles as the stage-0 carry-in, which is
  // what turns A + ~B into A + ~B + 1.
  localparam logic C_ADD = 1'b0;
  localparam logic C_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/adder_slice.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : adder_slice                                                |
// | Description : W-bit ripple adder with carry-in. One slice per pipeline   |
// |               stage.                                                     |
// | Ports       : a_i, b_i  - W-bit addends                                  |
// |               cin_i     - carry in                                       |
// |               sum_o     - W-bit sum                                      |
// |               cout_o    - carry out of the slice MSB                     |
// |               cmsb_o    - carry into the slice MSB                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module adder_slice
  import addsub_pkg::*;
#(
  parameter int W = C_DEFAULT_WIDTH / C_DEFAULT_STAGES
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  logic [W:0] w_full;

  assign w_full = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
  assign sum_o  = w_full[W-1:0];
  assign cout_o = w_full[W];

  // Each sum bit is a ^ b ^ carry-in, so the carry into the MSB can be
  // recovered from the MSB sum bit without a second adder (works for W=1).
  assign cmsb_o = a_i[W-1] ^ b_i[W-1] ^ w_full[W-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipelined_addsub                                           |
// | Description : Carry-pipelined adder/subtractor with valid/ready          |
// |               handshake. Operands are split into STAGES chunks of        |
// |               WIDTH/STAGES bits; stage k adds chunk k plus the carry     |
// |               registered by stage k-1. Latency STAGES, one beat/cycle.   |
// | Ports       : clk_i, rst_n_i (async, active-low)                         |
// |               in_valid_i/in_ready_o, a_i, b_i, sub_i (0=A+B, 1=A-B)      |
// |               out_valid_o/out_ready_i, sum_o, cout_o                     |
// |               ovf_o (only with ADDSUB_OVERFLOW_EN defined)               |
// | Options     : ADDSUB_OVERFLOW_EN - adds signed overflow output ovf_o     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = C_DEFAULT_WIDTH,   // >= 2, multiple of STAGES
  parameter int STAGES = C_DEFAULT_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef ADDSUB_OVERFLOW_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int C_W = WIDTH / STAGES;

  // Stage k keeps the (k+1) low result chunks finished so far; all stages
  // are packed back to back into r_res, stage k at offset W*k*(k+1)/2.
  localparam int C_RES_BITS  = C_W * STAGES * (STAGES + 1) / 2;
  // Stage k (k < STAGES-1) keeps the operand chunks still to be added,
  // WIDTH-W*(k+1) bits each for A and B, packed the same way.
  localparam int C_SKEW_BITS = (STAGES > 1) ? C_W * STAGES * (STAGES - 1) / 2 : 1;

  logic                   w_stall;
  logic                   w_en;
  logic [WIDTH-1:0]       w_b_eff;
  logic [STAGES-1:0]      w_cout;
  logic [STAGES-1:0]      w_cmsb;
  logic                   w_unused_cmsb;

  logic [STAGES-1:0]      r_valid;
  logic [STAGES-1:0]      r_carry;
  logic [C_RES_BITS-1:0]  r_res;
  logic [C_SKEW_BITS-1:0] r_a_skew;
  logic [C_SKEW_BITS-1:0] r_b_skew;

  // The whole pipeline advances as one unit; it only freezes when the
  // final result is held by downstream.
  assign w_stall    = r_valid[STAGES-1] & ~out_ready_i;
  assign w_en       = ~w_stall;
  assign in_ready_o = w_en;

  // B is inverted once at the input, so the skew registers carry the
  // effective addend and sub_i does not need to travel down the pipe.
  assign w_b_eff = (sub_i == C_SUB) ? ~b_i : b_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int C_RO  = C_W * k * (k + 1) / 2;
    localparam int C_RW  = C_W * (k + 1);
    localparam int C_REM = WIDTH - C_W * k;

    logic [C_REM-1:0] w_a_rest;
    logic [C_REM-1:0] w_b_rest;
    logic [C_W-1:0]   w_sum;
    logic [C_RW-1:0]  w_res_next;
    logic             w_cin;
    logic             w_vin;

    if (k == 0) begin : g_first
      assign w_a_rest   = a_i;
      assign w_b_rest   = w_b_eff;
      assign w_cin      = (sub_i == C_SUB);
      assign w_vin      = in_valid_i;
      assign w_res_next = w_sum;
    end else begin : g_next
      localparam int C_SO_PREV = (k - 1) * WIDTH - C_W * (k - 1) * k / 2;
      localparam int C_RO_PREV = C_W * (k - 1) * k / 2;
      assign w_a_rest   = r_a_skew[C_SO_PREV +: C_REM];
      assign w_b_rest   = r_b_skew[C_SO_PREV +: C_REM];
      assign w_cin      = r_carry[k-1];
      assign w_vin      = r_valid[k-1];
      assign w_res_next = {w_sum, r_res[C_RO_PREV +: C_W * k]};
    end

    adder_slice #(
      .W      (C_W)
    ) u_slice (
      .a_i    (w_a_rest[C_W-1:0]),
      .b_i    (w_b_rest[C_W-1:0]),
      .cin_i  (w_cin),
      .sum_o  (w_sum),
      .cout_o (w_cout[k]),
      .cmsb_o (w_cmsb[k])
    );

    // Data registers load even for bubbles; only the valid bit matters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_valid[k]          <= 1'b0;
        r_carry[k]          <= 1'b0;
        r_res[C_RO +: C_RW] <= '0;
      end else if (w_en) begin
        r_valid[k]          <= w_vin;
        r_carry[k]          <= w_cout[k];
        r_res[C_RO +: C_RW] <= w_res_next;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      localparam int C_SO = k * WIDTH - C_W * k * (k + 1) / 2;
      localparam int C_SW = WIDTH - C_W * (k + 1);

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          r_a_skew[C_SO +: C_SW] <= '0;
          r_b_skew[C_SO +: C_SW] <= '0;
        end else if (w_en) begin
          r_a_skew[C_SO +: C_SW] <= w_a_rest[C_REM-1:C_W];
          r_b_skew[C_SO +: C_SW] <= w_b_rest[C_REM-1:C_W];
        end
      end
    end
  end

  assign out_valid_o = r_valid[STAGES-1];
  assign sum_o       = r_res[C_RES_BITS-1 -: WIDTH];
  assign cout_o      = r_carry[STAGES-1];

  // Only the last slice's carry-into-MSB is meaningful (overflow); the
  // others fall out of the shared slice and are intentionally dropped.
  assign w_unused_cmsb = ^w_cmsb;

`ifdef ADDSUB_OVERFLOW_EN
  logic r_ovf;

  // Registered with the last stage so it lines up with sum_o/cout_o.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ovf <= 1'b0;
    end else if (w_en) begin
      r_ovf <= w_cmsb[STAGES-1] ^ w_cout[STAGES-1];
    end
  end

  assign ovf_o = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipelined_addsub                                        |
// | Description : Self-checking bench for pipelined_addsub (WIDTH=8,         |
// |               STAGES=2). A negedge monitor pushes a model result for     |
// |               every accepted beat and pops/compares on every result      |
// |               transfer; scenario tasks add direct latency/stall/reset    |
// |               checks. Honours ADDSUB_OVERFLOW_EN for ovf_o.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pipelined_addsub;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
`ifdef ADDSUB_OVERFLOW_EN
  localparam logic [9:0] C_MASK = 10'h3FF;
`else
  localparam logic [9:0] C_MASK = 10'h1FF;
`endif

  logic             clk_i       = 1'b0;
  logic             rst_n_i     = 1'b1;
  logic             in_valid_i  = 1'b0;
  logic             sub_i       = 1'b0;
  logic             out_ready_i = 1'b1;
  logic [WIDTH-1:0] a_i         = '0;
  logic [WIDTH-1:0] b_i         = '0;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             ovf_bit;
  logic [9:0]       obs_now;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [9:0]       sb_q[$];

  always #5 clk_i = ~clk_i;

`ifdef ADDSUB_OVERFLOW_EN
  logic ovf_o;
  assign ovf_bit = ovf_o;
`else
  assign ovf_bit = 1'b0;
`endif
  assign obs_now = {ovf_bit, cout_o, sum_o};

  pipelined_addsub #(
    .WIDTH       (WIDTH),
    .STAGES      (STAGES)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .sub_i       (sub_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sum_o       (sum_o),
    .cout_o      (cout_o)
`ifdef ADDSUB_OVERFLOW_EN
    ,
    .ovf_o       (ovf_o)
`endif
  );

  // Reference: {ovf, cout, sum} straight from 9-bit arithmetic.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic s);
    logic [7:0] be;
    logic [8:0] r;
    logic       v;
    be = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + {8'd0, s};
    v  = (a[7] == be[7]) && (r[7] != a[7]);
    return {v, r};
  endfunction

  // Scoreboard monitor: pop before push so a same-cycle accept never
  // satisfies its own output slot.
  logic       stall_prev = 1'b0;
  logic [9:0] obs_prev   = '0;
  logic [9:0] exp_v;

  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (stall_prev) begin
        n_checks++;
        if (out_valid_o !== 1'b1 || (obs_now & C_MASK) !== (obs_prev & C_MASK)) begin
          n_fail++;
          $display("FAIL hold_during_stall: got valid=%b data=%h, required valid=1 data=%h",
                   out_valid_o, obs_now & C_MASK, obs_prev & C_MASK);
        end
      end
      if (out_valid_o && out_ready_i) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got data=%h with no beat outstanding", obs_now & C_MASK);
        end else begin
          exp_v = sb_q.pop_front();
          if ((obs_now & C_MASK) !== (exp_v & C_MASK)) begin
            n_fail++;
            $display("FAIL scoreboard_result: got {ovf,cout,sum}=%h, required %h",
                     obs_now & C_MASK, exp_v & C_MASK);
          end
        end
      end
      if (in_valid_i && in_ready_o) sb_q.push_back(model(a_i, b_i, sub_i));
      stall_prev = out_valid_o && !out_ready_i;
      obs_prev   = obs_now;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic sync();
    @(posedge clk_i);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
    int guard;
    guard      = 0;
    a_i        = a;
    b_i        = b;
    sub_i      = s;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    while (!in_ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready_o=%b after %0d cycles, required 1", in_ready_o, guard);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 40) begin
      sync();
      guard++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    #1 rst_n_i = 1'b0;
    #2;
    n_checks++;
    if (out_valid_o !== 1'b0 || (obs_now & C_MASK) !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_async_outputs: got valid=%b data=%h, required 0/000",
               out_valid_o, obs_now & C_MASK);
    end
    n_checks++;
    if (in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready_o);
    end
    repeat (3) @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    sync();
    n_checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got valid=%b ready=%b, required 0/1", out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_basic_add();
    sync();
    send(8'h3C, 8'h05, 1'b0);
    in_valid_i = 1'b0;
    n_checks++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_valid: got out_valid=%b one cycle after accept, required 0", out_valid_o);
    end
    sync();
    n_checks++;
    if (out_valid_o !== 1'b1 || sum_o !== 8'h41 || cout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_add: got valid=%b sum=%h cout=%b, required 1/41/0", out_valid_o, sum_o, cout_o);
    end
    drain("basic");
  endtask

  task automatic test_carry_cross();
    sync();
    send(8'hFF, 8'h01, 1'b0);
    in_valid_i = 1'b0;
    sync();
    n_checks++;
    if (out_valid_o !== 1'b1 || sum_o !== 8'h00 || cout_o !== 1'b1 || ovf_bit !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_cross: got valid=%b sum=%h cout=%b ovf=%b, required 1/00/1/0",
               out_valid_o, sum_o, cout_o, ovf_bit);
    end
    drain("carry");
  endtask

  task automatic test_subtract();
    sync();
    send(8'h05, 8'h07, 1'b1);
    send(8'h80, 8'h01, 1'b1);
    in_valid_i = 1'b0;
    n_checks++;
    if (out_valid_o !== 1'b1 || sum_o !== 8'hFE || cout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: got valid=%b sum=%h cout=%b, required 1/FE/0", out_valid_o, sum_o, cout_o);
    end
    sync();
    n_checks++;
`ifdef ADDSUB_OVERFLOW_EN
    if (out_valid_o !== 1'b1 || sum_o !== 8'h7F || cout_o !== 1'b1 || ovf_o !== 1'b1) begin
`else
    if (out_valid_o !== 1'b1 || sum_o !== 8'h7F || cout_o !== 1'b1) begin
`endif
      n_fail++;
      $display("FAIL sub_overflow: got valid=%b sum=%h cout=%b ovf=%b, required 1/7F/1/1",
               out_valid_o, sum_o, cout_o, ovf_bit);
    end
    drain("sub");
  endtask

  task automatic test_back_to_back_stall();
    sync();
    fork
      begin
        send(8'h01, 8'h01, 1'b0);
        send(8'h02, 8'h02, 1'b0);
        send(8'h03, 8'h03, 1'b0);
        in_valid_i = 1'b0;
      end
      begin
        int guard;
        guard = 0;
        while (!out_valid_o && guard < 20) begin
          @(negedge clk_i);
          guard++;
        end
        n_checks++;
        if (guard >= 20) begin
          n_fail++;
          $display("FAIL b2b_first_result: out_valid=%b after %0d cycles, required 1", out_valid_o, guard);
        end
        @(posedge clk_i);
        #1 out_ready_i = 1'b0;
        repeat (3) begin
          @(negedge clk_i);
          n_checks++;
          if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_stall_ready: got in_ready=%b out_valid=%b, required 0/1",
                     in_ready_o, out_valid_o);
          end
        end
        @(posedge clk_i);
        #1 out_ready_i = 1'b1;
      end
    join
    drain("b2b");
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    sync();
    send(8'h10, 8'h20, 1'b0);
    send(8'h30, 8'h40, 1'b0);
    in_valid_i = 1'b0;
    #1 rst_n_i = 1'b0;
    #1;
    n_checks++;
    if (out_valid_o !== 1'b0 || (obs_now & C_MASK) !== 10'h000) begin
      n_fail++;
      $display("FAIL midflight_reset_clear: got valid=%b data=%h, required 0/000",
               out_valid_o, obs_now & C_MASK);
    end
    @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    sb_q.delete();
    repeat (6) begin
      @(negedge clk_i);
      if (out_valid_o) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midflight_no_result: got %0d valid cycles after reset, required 0", seen);
    end
  endtask

  task automatic test_random_bubbles();
    sync();
    fork
      begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        int         gap;
        for (int i = 0; i < 30; i++) begin
          ra  = 8'($urandom);
          rb  = 8'($urandom);
          rs  = 1'($urandom);
          gap = int'($urandom_range(0, 2));
          send(ra, rb, rs);
          in_valid_i = 1'b0;
          repeat (gap) sync();
        end
      end
      begin
        for (int c = 0; c < 60; c++) begin
          out_ready_i = ($urandom_range(0, 3) != 0);
          sync();
        end
        out_ready_i = 1'b1;
      end
    join
    out_ready_i = 1'b1;
    drain("random");
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_cross();
    test_subtract();
    test_back_to_back_stall();
    test_reset_midflight();
    test_random_bubbles();
    repeat (2) sync();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
